cpu_control_fsm: RTL and testbench

//  Multi-cycle RV32I control unit driving cpu_module: decodes ir_reg_out and sequences every datapath

---
 rtl/cpu_control_fsm_pkg.sv | 90 +++++++++
 rtl/cpu_control_fsm_if.sv | 52 +++++
 rtl/cpu_control_fsm_alu_decoder.sv | 47 ++++
 rtl/cpu_control_fsm.sv | 260 ++++++++++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the multi-cycle RV32I control unit: FSM state
// encoding, RV32I opcode constants, ALU operation codes, immediate-format
// codes, datapath mux select values and fault codes.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC_R,
      ST_EXEC_I,
      ST_ALU_WB,
      ST_LUI_WB,
      ST_MEM_ADDR,
      ST_MEM_READ,
      ST_LOAD_WB,
      ST_MEM_WRITE,
      ST_BRANCH,
      ST_EXEC_JALR,
      ST_LINK,
      ST_JUMP,
      ST_HALT
   } state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic [3:0] IMM_I   = 4'd0;
   localparam logic [3:0] IMM_S   = 4'd1;
   localparam logic [3:0] IMM_B   = 4'd2;
   localparam logic [3:0] IMM_U   = 4'd3;
   localparam logic [3:0] IMM_J   = 4'd4;
   localparam logic [3:0] IMM_LB  = 4'd5;
   localparam logic [3:0] IMM_LH  = 4'd6;
   localparam logic [3:0] IMM_LBU = 4'd7;
   localparam logic [3:0] IMM_LHU = 4'd8;
   localparam logic [3:0] IMM_LW  = 4'd9;

   localparam logic [1:0] RF_SRC_MEM = 2'b00;
   localparam logic [1:0] RF_SRC_ALU = 2'b01;
   localparam logic [1:0] RF_SRC_EXT = 2'b10;

   localparam logic [1:0] OP1_RS1    = 2'b00;
   localparam logic [1:0] OP1_PC     = 2'b01;
   localparam logic [1:0] OP1_OLD_PC = 2'b10;

   localparam logic [1:0] OP2_IMM  = 2'b00;
   localparam logic [1:0] OP2_FOUR = 2'b01;
   localparam logic [1:0] OP2_RS2  = 2'b10;
   localparam logic [1:0] OP2_ZERO = 2'b11;

   localparam logic [1:0] MODE_BYTE = 2'b00;
   localparam logic [1:0] MODE_HALF = 2'b01;
   localparam logic [1:0] MODE_WORD = 2'b10;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_SYSTEM  = 2'b10;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b11;

   // States that sit waiting on the memory handshake and are therefore
   // subject to the wait-cycle timeout.
   function automatic logic is_wait_state(state_t s);
      return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
   endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// ---------------------------------------------------------------------------
// cpu_control_fsm_if
// Bundle between the control FSM and the cpu_module datapath.
//  inputs to control : ir_reg_out[32], zero, mem_op_r
//  control outputs   : register enables, regfile/memory strobes, mux selects,
//                      alu_sel[4], imm_src[4], instr_mode[2], halted,
//                      fault[2], instret[32]
// master = control unit side, slave = datapath side.
// ---------------------------------------------------------------------------
interface cpu_control_fsm_if;

   logic [31:0] ir_reg_out;
   logic        zero;
   logic        mem_op_r;

   logic        pc_enable;
   logic        old_pc_enable;
   logic        ir_reg_enable;
   logic        mem_reg_enable;
   logic        alu_reg_enable;
   logic        rf_we;
   logic        mem_enable;
   logic        mem_write_enable;
   logic        memsel_mux_select;
   logic        alu_reg_mux_select;
   logic [1:0]  regfile_mux_select;
   logic [1:0]  opsel1_select;
   logic [1:0]  opsel2_select;
   logic [3:0]  alu_sel;
   logic [3:0]  imm_src;
   logic [1:0]  instr_mode;
   logic        halted;
   logic [1:0]  fault;
   logic [31:0] instret;

   modport master (
      input  ir_reg_out, zero, mem_op_r,
      output pc_enable, old_pc_enable, ir_reg_enable, mem_reg_enable, alu_reg_enable,
             rf_we, mem_enable, mem_write_enable, memsel_mux_select, alu_reg_mux_select,
             regfile_mux_select, opsel1_select, opsel2_select, alu_sel, imm_src,
             instr_mode, halted, fault, instret
   );

   modport slave (
      output ir_reg_out, zero, mem_op_r,
      input  pc_enable, old_pc_enable, ir_reg_enable, mem_reg_enable, alu_reg_enable,
             rf_we, mem_enable, mem_write_enable, memsel_mux_select, alu_reg_mux_select,
             regfile_mux_select, opsel1_select, opsel2_select, alu_sel, imm_src,
             instr_mode, halted, fault, instret
   );

endinterface

// File: rtl/cpu_control_fsm_alu_decoder.sv
// ---------------------------------------------------------------------------
// cpu_alu_decoder
// Combinational ALU operation decode for OP and OP-IMM instructions.
//  opcode[7], funct3[3], funct7[7] in
//  alu_sel[4] out : package ALU code (ADD for any other opcode)
//  illegal    out : funct7 not 0000000/0100000 where funct7 is meaningful
// ---------------------------------------------------------------------------
module cpu_alu_decoder
   import cpu_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] alu_sel,
   output logic       illegal
);

   logic is_reg;
   logic is_imm;

   assign is_reg = (opcode == OPC_OP);
   assign is_imm = (opcode == OPC_OP_IMM);

   // For OP-IMM the funct7 field is part of the immediate, so it only selects
   // SUB for register ops, and is only checked for legality on register ops
   // and on immediate shifts where it carries the SRLI/SRAI distinction.
   always_comb begin
      alu_sel = ALU_ADD;
      illegal = 1'b0;
      if (is_reg || is_imm) begin
         case (funct3)
            3'b000:  alu_sel = (is_reg && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_sel = ALU_SLL;
            3'b010:  alu_sel = ALU_SLT;
            3'b011:  alu_sel = ALU_SLTU;
            3'b100:  alu_sel = ALU_XOR;
            3'b101:  alu_sel = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
         endcase
         if (is_reg || funct3 == 3'b001 || funct3 == 3'b101) begin
            illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
         end
      end
   end

endmodule

// File: rtl/cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// cpu_control_fsm
// Multi-cycle RV32I control unit: decodes the latched instruction and
// sequences every datapath enable and mux select, with a memory-wait timeout
// and a retired-instruction counter.
//  clk   : system clock
//  reset : synchronous active-high; FSM to FETCH, counters/fault cleared,
//          all enables forced low while high
//  ctrl  : cpu_control_fsm_if.master (instruction/flags in, controls out)
// ---------------------------------------------------------------------------
module cpu_control_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 255
) (
   input  logic              clk,
   input  logic              reset,
   cpu_control_fsm_if.master ctrl
);

   localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

   state_t            state;
   state_t            next_state;
   logic [1:0]        fault_reg;
   logic [1:0]        fault_set;
   logic [31:0]       instret_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              wait_expired;
   logic              branch_taken;
   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [3:0]        dec_alu_sel;
   logic              dec_illegal;
   logic              unused_ir_fields;

   assign opcode           = ctrl.ir_reg_out[6:0];
   assign funct3           = ctrl.ir_reg_out[14:12];
   assign funct7           = ctrl.ir_reg_out[31:25];
   assign unused_ir_fields = ^{ctrl.ir_reg_out[24:15], ctrl.ir_reg_out[11:7]};
   assign wait_expired     = (wait_cnt == WAIT_W'(MEM_WAIT_MAX));

   assign ctrl.halted  = (state == ST_HALT);
   assign ctrl.fault   = fault_reg;
   assign ctrl.instret = instret_cnt;

   cpu_alu_decoder u_alu_decoder (
      .opcode  (opcode),
      .funct3  (funct3),
      .funct7  (funct7),
      .alu_sel (dec_alu_sel),
      .illegal (dec_illegal)
   );

   // Branch resolution: BEQ/BGE/BGEU take on a zero ALU result (equal, or
   // the SLT/SLTU "less than" came out false); BNE/BLT/BLTU on non-zero.
   always_comb begin
      branch_taken = 1'b0;
      case (funct3)
         3'b000, 3'b101, 3'b111: branch_taken = ctrl.zero;
         3'b001, 3'b100, 3'b110: branch_taken = !ctrl.zero;
         default:                branch_taken = 1'b0;
      endcase
   end

   // State register; reset abandons any in-flight access and restarts fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_FETCH;
      end else begin
         state <= next_state;
      end
   end

   // Memory wait counter: counts stalled cycles in a waiting state and starts
   // over whenever the FSM moves on, so each access gets its own budget.
   always_ff @(posedge clk) begin
      if (reset || next_state != state || !is_wait_state(state)) begin
         wait_cnt <= '0;
      end else if (!ctrl.mem_op_r) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Retired-instruction counter and sticky fault code. An instruction
   // retires when control returns to FETCH from anywhere else; the fault code
   // is captured once, on the transition into HALT.
   always_ff @(posedge clk) begin
      if (reset) begin
         instret_cnt <= 32'd0;
         fault_reg   <= FAULT_NONE;
      end else begin
         if (next_state == ST_FETCH && state != ST_FETCH) begin
            instret_cnt <= instret_cnt + 32'd1;
         end
         if (next_state == ST_HALT && state != ST_HALT) begin
            fault_reg <= fault_set;
         end
      end
   end

   // Next-state and datapath control decode. Everything defaults to idle;
   // while reset is high the defaults stand so no write can slip through.
   // A timed-out wait drops the memory request in the same cycle, but a
   // mem_op_r arriving on that last cycle still completes normally.
   always_comb begin
      next_state              = state;
      fault_set               = FAULT_NONE;
      ctrl.pc_enable          = 1'b0;
      ctrl.old_pc_enable      = 1'b0;
      ctrl.ir_reg_enable      = 1'b0;
      ctrl.mem_reg_enable     = 1'b0;
      ctrl.alu_reg_enable     = 1'b0;
      ctrl.rf_we              = 1'b0;
      ctrl.mem_enable         = 1'b0;
      ctrl.mem_write_enable   = 1'b0;
      ctrl.memsel_mux_select  = 1'b0;
      ctrl.alu_reg_mux_select = 1'b0;
      ctrl.regfile_mux_select = RF_SRC_MEM;
      ctrl.opsel1_select      = OP1_RS1;
      ctrl.opsel2_select      = OP2_IMM;
      ctrl.alu_sel            = ALU_ADD;
      ctrl.imm_src            = IMM_I;
      ctrl.instr_mode         = MODE_WORD;
      if (!reset) begin
         case (state)
            ST_FETCH: begin
               ctrl.mem_enable = 1'b1;
               if (ctrl.mem_op_r) begin
                  ctrl.ir_reg_enable      = 1'b1;
                  ctrl.old_pc_enable      = 1'b1;
                  ctrl.pc_enable          = 1'b1;
                  ctrl.opsel1_select      = OP1_PC;
                  ctrl.opsel2_select      = OP2_FOUR;
                  ctrl.alu_reg_mux_select = 1'b1;
                  next_state              = ST_DECODE;
               end else if (wait_expired) begin
                  ctrl.mem_enable = 1'b0;
                  fault_set       = FAULT_TIMEOUT;
                  next_state      = ST_HALT;
               end
            end
            ST_DECODE: begin
               ctrl.opsel1_select  = OP1_OLD_PC;
               ctrl.alu_reg_enable = 1'b1;
               ctrl.imm_src        = (opcode == OPC_JAL)   ? IMM_J :
                                     (opcode == OPC_AUIPC) ? IMM_U : IMM_B;
               case (opcode)
                  OPC_OP:                 next_state = ST_EXEC_R;
                  OPC_OP_IMM:             next_state = ST_EXEC_I;
                  OPC_LOAD, OPC_STORE:    next_state = ST_MEM_ADDR;
                  OPC_BRANCH:             next_state = ST_BRANCH;
                  OPC_JAL:                next_state = ST_LINK;
                  OPC_JALR:               next_state = ST_EXEC_JALR;
                  OPC_LUI:                next_state = ST_LUI_WB;
                  OPC_AUIPC:              next_state = ST_ALU_WB;
                  OPC_FENCE:              next_state = ST_FETCH;
                  OPC_SYSTEM: begin
                     fault_set  = FAULT_SYSTEM;
                     next_state = ST_HALT;
                  end
                  default: begin
                     fault_set  = FAULT_ILLEGAL;
                     next_state = ST_HALT;
                  end
               endcase
            end
            ST_EXEC_R, ST_EXEC_I: begin
               ctrl.opsel2_select = (state == ST_EXEC_R) ? OP2_RS2 : OP2_IMM;
               ctrl.alu_sel       = dec_alu_sel;
               if (dec_illegal) begin
                  fault_set  = FAULT_ILLEGAL;
                  next_state = ST_HALT;
               end else begin
                  ctrl.alu_reg_enable = 1'b1;
                  next_state          = ST_ALU_WB;
               end
            end
            ST_ALU_WB: begin
               ctrl.regfile_mux_select = RF_SRC_ALU;
               ctrl.rf_we              = 1'b1;
               next_state              = ST_FETCH;
            end
            ST_LUI_WB: begin
               ctrl.imm_src            = IMM_U;
               ctrl.regfile_mux_select = RF_SRC_EXT;
               ctrl.rf_we              = 1'b1;
               next_state              = ST_FETCH;
            end
            ST_MEM_ADDR: begin
               ctrl.imm_src        = (opcode == OPC_STORE) ? IMM_S : IMM_I;
               ctrl.alu_reg_enable = 1'b1;
               next_state          = (opcode == OPC_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ, ST_MEM_WRITE: begin
               ctrl.memsel_mux_select = 1'b1;
               ctrl.instr_mode        = funct3[1:0];
               ctrl.mem_enable        = 1'b1;
               ctrl.mem_write_enable  = (state == ST_MEM_WRITE);
               if (ctrl.mem_op_r) begin
                  ctrl.mem_reg_enable = (state == ST_MEM_READ);
                  next_state          = (state == ST_MEM_READ) ? ST_LOAD_WB : ST_FETCH;
               end else if (wait_expired) begin
                  ctrl.mem_enable       = 1'b0;
                  ctrl.mem_write_enable = 1'b0;
                  fault_set             = FAULT_TIMEOUT;
                  next_state            = ST_HALT;
               end
            end
            ST_LOAD_WB: begin
               case (funct3)
                  3'b000:  ctrl.imm_src = IMM_LB;
                  3'b001:  ctrl.imm_src = IMM_LH;
                  3'b100:  ctrl.imm_src = IMM_LBU;
                  3'b101:  ctrl.imm_src = IMM_LHU;
                  default: ctrl.imm_src = IMM_LW;
               endcase
               ctrl.regfile_mux_select = RF_SRC_EXT;
               ctrl.rf_we              = 1'b1;
               next_state              = ST_FETCH;
            end
            ST_BRANCH: begin
               ctrl.opsel2_select = OP2_RS2;
               case (funct3)
                  3'b000, 3'b001: ctrl.alu_sel = ALU_SUB;
                  3'b100, 3'b101: ctrl.alu_sel = ALU_SLT;
                  3'b110, 3'b111: ctrl.alu_sel = ALU_SLTU;
                  default:        ctrl.alu_sel = ALU_ADD;
               endcase
               ctrl.pc_enable = branch_taken;
               next_state     = ST_FETCH;
            end
            ST_EXEC_JALR: begin
               ctrl.alu_reg_enable = 1'b1;
               next_state          = ST_LINK;
            end
            ST_LINK: begin
               ctrl.opsel1_select      = OP1_PC;
               ctrl.opsel2_select      = OP2_ZERO;
               ctrl.alu_reg_mux_select = 1'b1;
               ctrl.regfile_mux_select = RF_SRC_ALU;
               ctrl.rf_we              = 1'b1;
               next_state              = ST_JUMP;
            end
            ST_JUMP: begin
               ctrl.pc_enable = 1'b1;
               next_state     = ST_FETCH;
            end
            ST_HALT: begin
               next_state = ST_HALT;
            end
            default: begin
               next_state = ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_cpu_control_fsm
// Directed bench for cpu_control_fsm: walks hand-encoded RV32I instructions
// through the FSM and compares the control outputs against hand-derived
// values for each state visited.
// No ports (top-level bench).
// ---------------------------------------------------------------------------
module tb_cpu_control_fsm;
   import cpu_ctrl_pkg::*;

   localparam logic [31:0] I_ADDI   = 32'h00500093;
   localparam logic [31:0] I_SUB    = 32'h402081B3;
   localparam logic [31:0] I_SRAI   = 32'h4030D093;
   localparam logic [31:0] I_BEQ    = 32'h00208463;
   localparam logic [31:0] I_BLT    = 32'h0020C463;
   localparam logic [31:0] I_BGEU   = 32'h0020F463;
   localparam logic [31:0] I_LBU    = 32'h00014083;
   localparam logic [31:0] I_JAL    = 32'h008000EF;
   localparam logic [31:0] I_EBREAK = 32'h00100073;
   localparam logic [31:0] I_BADF7  = 32'h802081B3;
   localparam logic [31:0] I_FENCE  = 32'h0000000F;
   localparam logic [31:0] I_SW     = 32'h0020A023;

   logic clk;
   logic reset;
   int   compareCount = 0;
   int   failCount    = 0;
   int   expRetired   = 0;

   cpu_control_fsm_if bus ();

   cpu_control_fsm #(.MEM_WAIT_MAX(255)) dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Enable vector order: pc, old_pc, ir_reg, mem_reg, alu_reg, rf_we,
   // mem_enable, mem_write_enable.
   function automatic logic [7:0] enVec();
      return {bus.pc_enable, bus.old_pc_enable, bus.ir_reg_enable, bus.mem_reg_enable,
              bus.alu_reg_enable, bus.rf_we, bus.mem_enable, bus.mem_write_enable};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] instr, input logic opR, input logic z);
      bus.ir_reg_out = instr;
      bus.mem_op_r   = opR;
      bus.zero       = z;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Completes a fetch in one cycle and leaves the FSM in DECODE.
   task automatic fetchInstr(input logic [31:0] instr);
      applyStimulus(instr, 1'b1, 1'b0);
      tick();
      applyStimulus(instr, 1'b0, 1'b0);
   endtask

   task automatic resetDut();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      expRetired = 0;
   endtask

   initial begin
      $display("[TB] start");
      reset = 1'b1;
      applyStimulus(32'h0, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("reset_enables_low", enVec(), 8'b0000_0000);
      reset = 1'b0;

      // ADDI with two stall cycles in FETCH
      applyStimulus(I_ADDI, 1'b0, 1'b0);
      checkOutput("reset_instret", bus.instret, 32'd0);
      checkOutput("reset_fault", bus.fault, 2'b00);
      checkOutput("reset_halted", bus.halted, 1'b0);
      checkOutput("fetch_wait_en", enVec(), 8'b0000_0010);
      checkOutput("fetch_memsel", bus.memsel_mux_select, 1'b0);
      checkOutput("fetch_mode", bus.instr_mode, MODE_WORD);
      tick();
      tick();
      applyStimulus(I_ADDI, 1'b1, 1'b0);
      checkOutput("fetch_done_en", enVec(), 8'b1110_0010);
      checkOutput("fetch_done_op1", bus.opsel1_select, 2'b01);
      checkOutput("fetch_done_op2", bus.opsel2_select, 2'b01);
      checkOutput("fetch_done_alu", bus.alu_sel, ALU_ADD);
      checkOutput("fetch_done_armux", bus.alu_reg_mux_select, 1'b1);
      tick();
      applyStimulus(I_ADDI, 1'b0, 1'b0);
      checkOutput("decode_en", enVec(), 8'b0000_1000);
      checkOutput("decode_op1", bus.opsel1_select, 2'b10);
      checkOutput("decode_op2", bus.opsel2_select, 2'b00);
      checkOutput("decode_imm", bus.imm_src, IMM_B);
      tick();
      checkOutput("execi_en", enVec(), 8'b0000_1000);
      checkOutput("execi_op1", bus.opsel1_select, 2'b00);
      checkOutput("execi_op2", bus.opsel2_select, 2'b00);
      checkOutput("execi_imm", bus.imm_src, IMM_I);
      checkOutput("execi_alu", bus.alu_sel, ALU_ADD);
      tick();
      checkOutput("aluwb_en", enVec(), 8'b0000_0100);
      checkOutput("aluwb_rfmux", bus.regfile_mux_select, 2'b01);
      checkOutput("aluwb_armux", bus.alu_reg_mux_select, 1'b0);
      tick();
      expRetired++;
      checkOutput("addi_back_fetch", enVec(), 8'b0000_0010);
      checkOutput("addi_instret", bus.instret, expRetired);

      // SUB in EXEC_R
      fetchInstr(I_SUB);
      tick();
      checkOutput("sub_alu", bus.alu_sel, ALU_SUB);
      checkOutput("sub_op2", bus.opsel2_select, 2'b10);
      checkOutput("sub_en", enVec(), 8'b0000_1000);
      tick();
      tick();
      expRetired++;

      // SRAI selects arithmetic shift from funct7[5]
      fetchInstr(I_SRAI);
      tick();
      checkOutput("srai_alu", bus.alu_sel, ALU_SRA);
      tick();
      tick();
      expRetired++;

      // BEQ taken then untaken
      fetchInstr(I_BEQ);
      tick();
      applyStimulus(I_BEQ, 1'b0, 1'b1);
      checkOutput("beq_taken_en", enVec(), 8'b1000_0000);
      checkOutput("beq_alu", bus.alu_sel, ALU_SUB);
      checkOutput("beq_op1", bus.opsel1_select, 2'b00);
      checkOutput("beq_op2", bus.opsel2_select, 2'b10);
      checkOutput("beq_armux", bus.alu_reg_mux_select, 1'b0);
      tick();
      expRetired++;
      checkOutput("beq_taken_fetch", enVec(), 8'b0000_0010);
      checkOutput("beq_taken_instret", bus.instret, expRetired);
      fetchInstr(I_BEQ);
      tick();
      applyStimulus(I_BEQ, 1'b0, 1'b0);
      checkOutput("beq_untaken_en", enVec(), 8'b0000_0000);
      tick();
      expRetired++;
      checkOutput("beq_untaken_fetch", enVec(), 8'b0000_0010);

      // BLT taken on non-zero SLT; BGEU untaken on non-zero SLTU
      fetchInstr(I_BLT);
      tick();
      checkOutput("blt_taken_en", enVec(), 8'b1000_0000);
      checkOutput("blt_alu", bus.alu_sel, ALU_SLT);
      tick();
      expRetired++;
      fetchInstr(I_BGEU);
      tick();
      checkOutput("bgeu_untaken_en", enVec(), 8'b0000_0000);
      checkOutput("bgeu_alu", bus.alu_sel, ALU_SLTU);
      tick();
      expRetired++;
      checkOutput("branch_instret", bus.instret, expRetired);

      // LBU with one stall cycle in MEM_READ
      fetchInstr(I_LBU);
      tick();
      checkOutput("lbu_addr_en", enVec(), 8'b0000_1000);
      checkOutput("lbu_addr_imm", bus.imm_src, IMM_I);
      tick();
      checkOutput("lbu_read_wait_en", enVec(), 8'b0000_0010);
      checkOutput("lbu_read_memsel", bus.memsel_mux_select, 1'b1);
      checkOutput("lbu_read_mode", bus.instr_mode, MODE_BYTE);
      tick();
      applyStimulus(I_LBU, 1'b1, 1'b0);
      checkOutput("lbu_read_done_en", enVec(), 8'b0001_0010);
      tick();
      applyStimulus(I_LBU, 1'b0, 1'b0);
      checkOutput("lbu_wb_en", enVec(), 8'b0000_0100);
      checkOutput("lbu_wb_imm", bus.imm_src, IMM_LBU);
      checkOutput("lbu_wb_rfmux", bus.regfile_mux_select, 2'b10);
      tick();
      expRetired++;
      checkOutput("lbu_instret", bus.instret, expRetired);

      // JAL x1,+8
      fetchInstr(I_JAL);
      checkOutput("jal_decode_imm", bus.imm_src, IMM_J);
      tick();
      checkOutput("jal_link_en", enVec(), 8'b0000_0100);
      checkOutput("jal_link_op1", bus.opsel1_select, 2'b01);
      checkOutput("jal_link_op2", bus.opsel2_select, 2'b11);
      checkOutput("jal_link_armux", bus.alu_reg_mux_select, 1'b1);
      checkOutput("jal_link_rfmux", bus.regfile_mux_select, 2'b01);
      tick();
      checkOutput("jal_jump_en", enVec(), 8'b1000_0000);
      checkOutput("jal_jump_armux", bus.alu_reg_mux_select, 1'b0);
      tick();
      expRetired++;
      checkOutput("jal_instret", bus.instret, expRetired);

      // EBREAK halts with the system fault and stays halted
      fetchInstr(I_EBREAK);
      tick();
      applyStimulus(I_EBREAK, 1'b1, 1'b0);
      checkOutput("ebreak_halted", bus.halted, 1'b1);
      checkOutput("ebreak_fault", bus.fault, 2'b10);
      checkOutput("halt_en", enVec(), 8'b0000_0000);
      tick();
      checkOutput("halt_sticky", bus.halted, 1'b1);
      checkOutput("halt_instret", bus.instret, expRetired);
      resetDut();
      applyStimulus(I_EBREAK, 1'b0, 1'b0);
      checkOutput("post_reset_fault", bus.fault, 2'b00);
      checkOutput("post_reset_halted", bus.halted, 1'b0);
      checkOutput("post_reset_instret", bus.instret, 32'd0);

      // Unknown opcode and bad funct7 both raise illegal
      fetchInstr(32'hFFFF_FFFF);
      tick();
      checkOutput("ones_halted", bus.halted, 1'b1);
      checkOutput("ones_fault", bus.fault, 2'b01);
      resetDut();
      fetchInstr(I_BADF7);
      tick();
      tick();
      checkOutput("badf7_halted", bus.halted, 1'b1);
      checkOutput("badf7_fault", bus.fault, 2'b01);

      // Fetch timeout: request held for 255 cycles, dropped on the 256th
      resetDut();
      applyStimulus(I_ADDI, 1'b0, 1'b0);
      repeat (254) tick();
      checkOutput("timeout_last_wait_en", enVec(), 8'b0000_0010);
      tick();
      checkOutput("timeout_drop_en", enVec(), 8'b0000_0000);
      checkOutput("timeout_not_yet_halted", bus.halted, 1'b0);
      tick();
      checkOutput("timeout_halted", bus.halted, 1'b1);
      checkOutput("timeout_fault", bus.fault, 2'b11);

      // mem_op_r on the final wait cycle still completes the fetch
      resetDut();
      applyStimulus(I_ADDI, 1'b0, 1'b0);
      repeat (255) tick();
      applyStimulus(I_ADDI, 1'b1, 1'b0);
      checkOutput("late_ack_en", enVec(), 8'b1110_0010);
      tick();
      applyStimulus(I_ADDI, 1'b0, 1'b0);
      checkOutput("late_ack_not_halted", bus.halted, 1'b0);
      checkOutput("late_ack_decode_en", enVec(), 8'b0000_1000);
      tick();
      tick();
      tick();
      expRetired++;

      // FENCE retires straight from DECODE
      fetchInstr(I_FENCE);
      tick();
      expRetired++;
      checkOutput("fence_fetch_en", enVec(), 8'b0000_0010);
      checkOutput("fence_instret", bus.instret, expRetired);

      // SW interrupted by reset while waiting in MEM_WRITE
      fetchInstr(I_SW);
      tick();
      checkOutput("sw_addr_imm", bus.imm_src, IMM_S);
      tick();
      checkOutput("sw_write_en", enVec(), 8'b0000_0011);
      checkOutput("sw_write_memsel", bus.memsel_mux_select, 1'b1);
      checkOutput("sw_write_mode", bus.instr_mode, MODE_WORD);
      tick();
      reset = 1'b1;
      applyStimulus(I_SW, 1'b1, 1'b0);
      checkOutput("sw_reset_en", enVec(), 8'b0000_0000);
      tick();
      reset = 1'b0;
      applyStimulus(I_SW, 1'b0, 1'b0);
      checkOutput("sw_reset_fetch_en", enVec(), 8'b0000_0010);
      checkOutput("sw_reset_instret", bus.instret, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
